cpu_mem_responder: RTL and testbench



---
 rtl/cpu_bus_pkg.sv | 16 +
 rtl/mem_resp_ram.sv | 27 ++
 rtl/cpu_mem_responder.sv | 126 ++++++++++++
 tb/tb_cpu_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the 16-bit CPU bus memory responder:
// default widths, FSM state encoding and the out-of-range read pattern.
package cpu_bus_pkg;

    localparam int BUS_DATA_W = 16;
    localparam int BUS_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic [15:0] ERR_DATA = 16'hDEAD;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port word RAM: synchronous write, asynchronous read of the
// (already registered) address. The array is never reset.
module mem_resp_ram
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W,
    parameter int DEPTH  = 256,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU bus: captures one request, waits
// WAIT_CYC cycles, then answers with a single-cycle ready pulse.
module cpu_mem_responder
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W   = BUS_DATA_W,
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic              c,
    input  logic              r,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              we,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic [1:0]        state_dbg
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake: re/we are levels sampled only in IDLE; the request is
    // complete on the single cycle ready=1, when rdata/err are valid.
    // A request still held the cycle after ready starts a new transaction.
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              resp;
    logic              oob;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign resp   = (state_q == ST_RESP);
    assign oob    = (32'(addr_q) >= 32'(DEPTH));
    assign ram_we = resp && wr_q && !oob;

    mem_resp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk_i   (c),
        .we_i    (ram_we),
        .addr_i  (addr_q[AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (re || we) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    wr_d    = we;
                    if (WAIT_CYC == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYC);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read results are presented combinationally during RESP and then held
    // in rdata_q/err_q until the next completion updates them.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (resp) begin
            err_d = oob;
            if (!wr_q) begin
                rdata_d = oob ? DATA_W'(ERR_DATA) : ram_rdata;
            end
        end
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rdata     = rdata_d;
    assign err       = err_d;
    assign ready     = resp;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: two instances (WAIT_CYC=2 and WAIT_CYC=0)
// against a transaction-level model plus directed literal expectations.
module tb_cpu_mem_responder;

    localparam int DEPTH = 256;
    localparam int WC [2] = '{2, 0};

    logic        c = 1'b0;
    logic        r;
    logic [1:0]  re_s, we_s, ready_s, err_s;
    logic [15:0] addr_s [2];
    logic [15:0] wdata_s [2];
    logic [15:0] rdata_s [2];
    logic [1:0]  st_s [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // transaction-level model state, one slot per instance
    bit          m_busy [2];
    int          m_k [2];
    logic [15:0] m_addr [2];
    logic [15:0] m_wdata [2];
    bit          m_wr [2];
    logic [15:0] m_mem [2][DEPTH];
    bit          m_known [2][DEPTH];
    bit          exp_ready [2];
    logic [15:0] exp_rdata [2];
    bit          exp_err [2];
    bit          exp_known [2];

    cpu_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYC(2)) dut2 (
        .c(c), .r(r), .addr(addr_s[0]), .wdata(wdata_s[0]), .re(re_s[0]), .we(we_s[0]),
        .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0]), .state_dbg(st_s[0])
    );

    cpu_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYC(0)) dut0 (
        .c(c), .r(r), .addr(addr_s[1]), .wdata(wdata_s[1]), .re(re_s[1]), .we(we_s[1]),
        .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1]), .state_dbg(st_s[1])
    );

    // clock / reset
    initial forever #5 c = ~c;
    initial forever begin
        @(posedge c);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // model: a captured request completes WAIT_CYC edges later, commits
    // its write one edge after that, and frees the bus
    initial forever begin
        @(posedge c or negedge r);
        for (int d = 0; d < 2; d++) begin
            if (!r) begin
                m_busy[d] = 0; m_k[d] = 0;
                exp_ready[d] = 0; exp_rdata[d] = 16'h0; exp_err[d] = 0; exp_known[d] = 1;
            end else begin
                if (!m_busy[d]) begin
                    if (re_s[d] || we_s[d]) begin
                        m_busy[d] = 1; m_k[d] = 0;
                        m_addr[d] = addr_s[d]; m_wdata[d] = wdata_s[d]; m_wr[d] = we_s[d];
                    end
                end else begin
                    m_k[d]++;
                    if (m_k[d] == WC[d] + 1) begin
                        m_busy[d] = 0;
                        if (m_wr[d] && m_addr[d] < DEPTH) begin
                            m_mem[d][m_addr[d][7:0]]   = m_wdata[d];
                            m_known[d][m_addr[d][7:0]] = 1;
                        end
                    end
                end
                exp_ready[d] = m_busy[d] && (m_k[d] == WC[d]);
                if (exp_ready[d]) begin
                    exp_err[d] = (m_addr[d] >= DEPTH);
                    if (!m_wr[d]) begin
                        if (m_addr[d] >= DEPTH) begin
                            exp_rdata[d] = 16'hDEAD; exp_known[d] = 1;
                        end else begin
                            exp_rdata[d] = m_mem[d][m_addr[d][7:0]];
                            exp_known[d] = m_known[d][m_addr[d][7:0]];
                        end
                    end
                end
            end
        end
    end

    // scoreboard compare on every falling edge
    initial forever begin
        @(negedge c);
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("dut%0d_ready", d), 32'(ready_s[d]), 32'(exp_ready[d]));
                check($sformatf("dut%0d_err", d), 32'(err_s[d]), 32'(exp_err[d]));
                if (exp_known[d])
                    check($sformatf("dut%0d_rdata", d), 32'(rdata_s[d]), 32'(exp_rdata[d]));
            end
        end
    end

    // driver: one transaction, returns latency (edges from capture to ready)
    task automatic do_txn(input int d, input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, output int lat, output logic [15:0] rv,
                          output logic ev, output int rcyc);
        lat = -1; rv = 16'h0; ev = 1'b0; rcyc = 0;
        @(posedge c); #1;
        re_s[d] = rd; we_s[d] = wr; addr_s[d] = a; wdata_s[d] = wd;
        @(posedge c); #1;
        re_s[d] = 1'b0; we_s[d] = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge c);
            if (ready_s[d]) begin
                lat = j + 1; rv = rdata_s[d]; ev = err_s[d]; rcyc = cyc;
                break;
            end
        end
    endtask

    int lat, rc_a, rc_b, npulse, first, second, consec;
    logic [15:0] rv;
    logic ev;
    bit prev;

    initial begin
        r = 1'b0;
        re_s = '0; we_s = '0;
        addr_s = '{16'h0, 16'h0}; wdata_s = '{16'h0, 16'h0};
        repeat (3) @(posedge c);
        #1 r = 1'b1;
        chk_en = 1'b1;

        // reset mid-WAIT aborts a write
        do_txn(0, 0, 1, 16'h0010, 16'hAAAA, lat, rv, ev, rc_a);
        check("t1_wr_latency", 32'(lat), 32'd3);
        do_txn(0, 1, 0, 16'h0010, 16'h0, lat, rv, ev, rc_a);
        check("t1_rd_old", 32'(rv), 32'hAAAA);
        @(posedge c); #1;
        we_s[0] = 1'b1; addr_s[0] = 16'h0010; wdata_s[0] = 16'h1234;
        @(posedge c); #1;
        we_s[0] = 1'b0;
        r = 1'b0;
        @(negedge c);
        check("t1_rst_ready", 32'(ready_s[0]), 32'd0);
        check("t1_rst_rdata", 32'(rdata_s[0]), 32'h0);
        check("t1_rst_err", 32'(err_s[0]), 32'd0);
        check("t1_rst_state2", 32'(st_s[0]), 32'd0);
        check("t1_rst_state0", 32'(st_s[1]), 32'd0);
        @(posedge c); #1 r = 1'b1;
        do_txn(0, 1, 0, 16'h0010, 16'h0, lat, rv, ev, rc_a);
        check("t1_rd_after_rst", 32'(rv), 32'hAAAA);

        // write then read, WAIT_CYC=2
        do_txn(0, 0, 1, 16'h00A5, 16'hBEEF, lat, rv, ev, rc_a);
        check("t2_wr_latency", 32'(lat), 32'd3);
        do_txn(0, 1, 0, 16'h00A5, 16'h0, lat, rv, ev, rc_a);
        check("t2_rd_latency", 32'(lat), 32'd3);
        check("t2_rd_data", 32'(rv), 32'hBEEF);
        check("t2_rd_err", 32'(ev), 32'd0);

        // WAIT_CYC=0
        do_txn(1, 0, 1, 16'h0000, 16'h5A5A, lat, rv, ev, rc_a);
        do_txn(1, 0, 1, 16'h0001, 16'h1357, lat, rv, ev, rc_a);
        do_txn(1, 1, 0, 16'h0000, 16'h0, lat, rv, ev, rc_a);
        check("t3_rd_latency", 32'(lat), 32'd1);
        check("t3_rd0_data", 32'(rv), 32'h5A5A);
        do_txn(1, 1, 0, 16'h0001, 16'h0, lat, rv, ev, rc_b);
        check("t3_rd1_data", 32'(rv), 32'h1357);
        check("t3_b2b_spacing", 32'(rc_b - rc_a), 32'd2);

        // out of range
        do_txn(0, 0, 1, 16'h0000, 16'h4242, lat, rv, ev, rc_a);
        do_txn(0, 0, 1, 16'h0100, 16'h1111, lat, rv, ev, rc_a);
        check("t4_wr_err", 32'(ev), 32'd1);
        do_txn(0, 1, 0, 16'h0100, 16'h0, lat, rv, ev, rc_a);
        check("t4_rd_dead", 32'(rv), 32'hDEAD);
        check("t4_rd_err", 32'(ev), 32'd1);
        do_txn(0, 1, 0, 16'h0000, 16'h0, lat, rv, ev, rc_a);
        check("t4_word0", 32'(rv), 32'h4242);
        check("t4_word0_err", 32'(ev), 32'd0);

        // re and we together behave as a write
        do_txn(0, 1, 1, 16'h0020, 16'h7777, lat, rv, ev, rc_a);
        check("t5_rdata_held", 32'(rv), 32'h4242);
        do_txn(0, 1, 0, 16'h0020, 16'h0, lat, rv, ev, rc_a);
        check("t5_rd_data", 32'(rv), 32'h7777);

        // held request for 10 cycles
        @(posedge c); #1;
        re_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 16'h00A5;
        npulse = 0; first = -1; second = -1; consec = 0; prev = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge c);
            if (ready_s[0]) begin
                if (prev) consec++;
                if (npulse == 0) first = j;
                else if (npulse == 1) second = j;
                npulse++;
            end
            prev = ready_s[0];
        end
        @(posedge c); #1;
        re_s[0] = 1'b0;
        check("t6_pulses", 32'(npulse), 32'd2);
        check("t6_spacing", 32'(second - first), 32'd4);
        check("t6_consecutive", 32'(consec), 32'd0);
        repeat (8) @(posedge c);

        @(negedge c);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
